// File: rtl/miso_cal_pkg.sv
// rtl/miso_cal_pkg.sv - shared state encoding and default constants for the MISO phase calibrator
package miso_cal_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SET_PHASE = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_CHECK     = 3'd4,
        S_PICK      = 3'd5,
        S_DONE      = 3'd6
    } cal_state_e;

    localparam int DEF_PHASE_W = 4;
    localparam int DEF_REPEATS = 4;
    localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/miso_phase_calibrator_if.sv
// rtl/miso_phase_calibrator_if.sv - read request / MISO return channel between calibrator and SPI sequencer
interface miso_phase_calibrator_if #(
    parameter int WORD_W = 32
) ();
    logic              cmd_req;
    logic              cmd_ack;
    logic              miso_valid;
    logic [WORD_W-1:0] miso_word;

    modport master (
        output cmd_req,
        input  cmd_ack,
        input  miso_valid,
        input  miso_word
    );

    modport slave (
        input  cmd_req,
        output cmd_ack,
        output miso_valid,
        output miso_word
    );
endinterface

// File: rtl/miso_cal_window_finder.sv
// rtl/miso_cal_window_finder.sv - serial longest-run search over the pass mask, centre of the first widest run
module miso_cal_window_finder #(
    parameter int NUM_PHASES = 10,
    parameter int PHASE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [NUM_PHASES-1:0] mask,
    output logic [PHASE_W-1:0]    result,
    output logic                  found,
    output logic                  valid
);
    localparam int IDX_W = $clog2(NUM_PHASES + 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_PHASES);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cur_start;
    logic [IDX_W-1:0] cur_len;
    logic [IDX_W-1:0] best_start;
    logic [IDX_W-1:0] best_len;
    logic [IDX_W-1:0] ext_len;
    logic [IDX_W-1:0] ext_start;
    logic [IDX_W-1:0] half;

    // Current run extended by the bit under inspection
    always_comb begin
        ext_len   = cur_len + 1'b1;
        ext_start = (cur_len == '0) ? idx : cur_start;
    end

    // One mask bit per cycle; strict compare keeps the earliest run on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (!run) begin
            idx        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (idx != IDX_END) begin
            if (mask[idx]) begin
                cur_len   <= ext_len;
                cur_start <= ext_start;
                if (ext_len > best_len) begin
                    best_len   <= ext_len;
                    best_start <= ext_start;
                end
            end else begin
                cur_len <= '0;
            end
            idx <= idx + 1'b1;
        end
    end

    // Centre of the best run, rounded towards its start
    always_comb begin
        half   = (best_len - 1'b1) >> 1;
        result = PHASE_W'(best_start + half);
        found  = (best_len != '0);
        valid  = run && (idx == IDX_END);
    end

endmodule

// File: rtl/miso_phase_calibrator.sv
// rtl/miso_phase_calibrator.sv - sweeps MISO sampling phase, scores each phase, centres on the widest passing window
module miso_phase_calibrator
    import miso_cal_pkg::*;
#(
    parameter int NUM_PHASES    = 10,
    parameter int PHASE_W       = DEF_PHASE_W,
    parameter int WORD_W        = 32,
    parameter int REPEATS       = DEF_REPEATS,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int DEFAULT_PHASE = 0
) (
    input  logic                    dataclk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [WORD_W-1:0]       expected_word,
    input  logic                    manual_en,
    input  logic [PHASE_W-1:0]      manual_phase,
    miso_phase_calibrator_if.master seq,
    output logic [PHASE_W-1:0]      phase_select,
    output logic                    busy,
    output logic                    done,
    output logic                    cal_ok,
    output logic [NUM_PHASES-1:0]   pass_mask
);
    localparam int RPT_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(REPEATS - 1);
    localparam logic [TO_W-1:0]    TO_MAX     = TO_W'(TIMEOUT);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W-1:0] RST_PHASE  = PHASE_W'(DEFAULT_PHASE);

    cal_state_e         state;
    logic [PHASE_W-1:0] scan_phase;
    logic [PHASE_W-1:0] cal_phase;
    logic [RPT_W-1:0]   rep_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [WORD_W-1:0]  word_q;
    logic [PHASE_W-1:0] win_result;
    logic               win_found;
    logic               win_valid;

    miso_cal_window_finder #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W)
    ) u_window (
        .clk    (dataclk),
        .rst_n  (reset_n),
        .run    (state == S_PICK),
        .mask   (pass_mask),
        .result (win_result),
        .found  (win_found),
        .valid  (win_valid)
    );

    // Calibration sequencer, timeout counter and registered phase_select mux
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            scan_phase   <= '0;
            cal_phase    <= RST_PHASE;
            rep_cnt      <= '0;
            to_cnt       <= '0;
            word_q       <= '0;
            seq.cmd_req  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cal_ok       <= 1'b0;
            pass_mask    <= '0;
            phase_select <= RST_PHASE;
        end else begin
            done <= 1'b0;
            // DONE already holds the new cal_phase, so hand it over one cycle after done
            if (busy && state != S_DONE) begin
                phase_select <= scan_phase;
            end else if (manual_en) begin
                phase_select <= manual_phase;
            end else begin
                phase_select <= cal_phase;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SET_PHASE;
                        scan_phase <= '0;
                        pass_mask  <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_SET_PHASE: begin
                    rep_cnt     <= '0;
                    seq.cmd_req <= 1'b1;
                    state       <= S_REQ;
                end
                S_REQ: begin
                    if (seq.cmd_ack) begin
                        seq.cmd_req <= 1'b0;
                        to_cnt      <= '0;
                        state       <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (seq.miso_valid) begin
                        word_q <= seq.miso_word;
                        state  <= S_CHECK;
                    end else if (to_cnt == TO_MAX) begin
                        if (scan_phase == LAST_PHASE) begin
                            state <= S_PICK;
                        end else begin
                            scan_phase <= scan_phase + 1'b1;
                            state      <= S_SET_PHASE;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (word_q == expected_word && rep_cnt != RPT_LAST) begin
                        rep_cnt     <= rep_cnt + 1'b1;
                        seq.cmd_req <= 1'b1;
                        state       <= S_REQ;
                    end else begin
                        if (word_q == expected_word) begin
                            pass_mask[scan_phase] <= 1'b1;
                        end
                        if (scan_phase == LAST_PHASE) begin
                            state <= S_PICK;
                        end else begin
                            scan_phase <= scan_phase + 1'b1;
                            state      <= S_SET_PHASE;
                        end
                    end
                end
                S_PICK: begin
                    if (win_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (win_found) begin
                            cal_phase <= win_result;
                            cal_ok    <= 1'b1;
                        end else begin
                            cal_ok    <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miso_phase_calibrator.sv
// tb/tb_miso_phase_calibrator.sv - directed self-checking bench for miso_phase_calibrator
module tb_miso_phase_calibrator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] expected_word;
    logic        manual_en;
    logic [3:0]  manual_phase;
    logic [3:0]  phase_select;
    logic        busy;
    logic        done;
    logic        cal_ok;
    logic [9:0]  pass_mask;

    int checks = 0;
    int errors = 0;

    logic [15:0] pass_pat = '0;
    logic [15:0] noresp   = '0;
    int          ack_delay = 0;
    bit          spurious  = 0;
    int          hs_count  = 0;
    int          done_cnt  = 0;
    int          req_drop_err = 0;
    int          req_after_ack_err = 0;

    miso_phase_calibrator_if #(.WORD_W(32)) ifc ();

    miso_phase_calibrator dut (
        .dataclk       (clk),
        .reset_n       (rst_n),
        .start         (start),
        .expected_word (expected_word),
        .manual_en     (manual_en),
        .manual_phase  (manual_phase),
        .seq           (ifc.master),
        .phase_select  (phase_select),
        .busy          (busy),
        .done          (done),
        .cal_ok        (cal_ok),
        .pass_mask     (pass_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Sequencer model: ack after a delay, then return a word chosen by the current phase
    initial begin
        int d;
        int ph;
        ifc.cmd_ack    = 1'b0;
        ifc.miso_valid = 1'b0;
        ifc.miso_word  = '0;
        forever begin
            @(negedge clk);
            if (ifc.cmd_req === 1'b1) begin
                d = (ack_delay < 0) ? (hs_count % 6) : ack_delay;
                for (int k = 0; k < d; k++) begin
                    if (spurious && k == 0) begin
                        ifc.miso_valid = 1'b1;
                        ifc.miso_word  = expected_word ^ 32'h8000_0000;
                    end
                    @(negedge clk);
                    ifc.miso_valid = 1'b0;
                    if (ifc.cmd_req !== 1'b1) req_drop_err++;
                end
                ifc.cmd_ack = 1'b1;
                hs_count++;
                @(negedge clk);
                ifc.cmd_ack = 1'b0;
                if (ifc.cmd_req !== 1'b0) req_after_ack_err++;
                ph = int'(phase_select);
                if (!noresp[ph]) begin
                    @(negedge clk);
                    ifc.miso_valid = 1'b1;
                    ifc.miso_word  = pass_pat[ph] ? expected_word : (expected_word ^ 32'h0001_0000);
                    @(negedge clk);
                    ifc.miso_valid = 1'b0;
                end
            end
        end
    end

    task automatic run_cal(input logic [15:0] pat, input logic [15:0] nr, input int dly, input bit spur,
                           output bit got_done, output logic [9:0] m, output logic c_ok,
                           output logic [3:0] ps, output int hs);
        pass_pat = pat;
        noresp   = nr;
        ack_delay = dly;
        spurious = spur;
        hs_count = 0;
        got_done = 0;
        m = '0; c_ok = 1'b0; ps = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 5000 && !got_done; i++) begin
            if (done === 1'b1) begin
                got_done = 1;
                m = pass_mask;
                c_ok = cal_ok;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        ps = phase_select;
        hs = hs_count;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (phase_select !== 4'd0) begin errors++; $display("FAIL reset_phase_select got %0d want 0", phase_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (cal_ok !== 1'b0) begin errors++; $display("FAIL reset_cal_ok got %b want 0", cal_ok); end
        checks++; if (pass_mask !== 10'h000) begin errors++; $display("FAIL reset_pass_mask got %h want 000", pass_mask); end
        checks++; if (ifc.cmd_req !== 1'b0) begin errors++; $display("FAIL reset_cmd_req got %b want 0", ifc.cmd_req); end
    endtask

    task automatic test_window_select;
        bit gd; logic [9:0] m; logic c; logic [3:0] ps; int hs;
        run_cal(16'h00E6, 16'h0000, 0, 0, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL win_a_done got %b want 1", gd); end
        checks++; if (m !== 10'h0E6) begin errors++; $display("FAIL win_a_mask got %h want 0e6", m); end
        checks++; if (ps !== 4'd6) begin errors++; $display("FAIL win_a_phase got %0d want 6", ps); end
        run_cal(16'h0033, 16'h0000, 0, 0, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL win_b_done got %b want 1", gd); end
        checks++; if (m !== 10'h033) begin errors++; $display("FAIL win_b_mask got %h want 033", m); end
        checks++; if (ps !== 4'd0) begin errors++; $display("FAIL win_b_phase got %0d want 0", ps); end
    endtask

    task automatic test_single_window;
        bit gd; logic [9:0] m; logic c; logic [3:0] ps; int hs;
        run_cal(16'h0078, 16'h0000, 0, 0, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", gd); end
        checks++; if (m !== 10'h078) begin errors++; $display("FAIL single_mask got %h want 078", m); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL single_cal_ok got %b want 1", c); end
        checks++; if (ps !== 4'd4) begin errors++; $display("FAIL single_phase got %0d want 4", ps); end
        checks++; if (hs !== 22) begin errors++; $display("FAIL single_handshakes got %0d want 22", hs); end
    endtask

    task automatic test_no_pass;
        bit gd; logic [9:0] m; logic c; logic [3:0] ps; int hs;
        run_cal(16'h0000, 16'h0000, 0, 0, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL nopass_done got %b want 1", gd); end
        checks++; if (m !== 10'h000) begin errors++; $display("FAIL nopass_mask got %h want 000", m); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL nopass_cal_ok got %b want 0", c); end
        checks++; if (ps !== 4'd4) begin errors++; $display("FAIL nopass_phase got %0d want 4", ps); end
        checks++; if (hs !== 10) begin errors++; $display("FAIL nopass_handshakes got %0d want 10", hs); end
    endtask

    task automatic test_manual;
        manual_phase = 4'd7;
        manual_en = 1'b1;
        checks++; if (phase_select !== 4'd4) begin errors++; $display("FAIL manual_same_cycle got %0d want 4", phase_select); end
        @(negedge clk);
        checks++; if (phase_select !== 4'd7) begin errors++; $display("FAIL manual_phase got %0d want 7", phase_select); end
        manual_en = 1'b0;
        @(negedge clk);
        checks++; if (phase_select !== 4'd4) begin errors++; $display("FAIL manual_release got %0d want 4", phase_select); end
    endtask

    task automatic test_timeout;
        bit gd; logic [9:0] m; logic c; logic [3:0] ps; int hs;
        run_cal(16'h03FF, 16'h0004, 0, 0, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL timeout_done got %b want 1", gd); end
        checks++; if (m !== 10'h3FB) begin errors++; $display("FAIL timeout_mask got %h want 3fb", m); end
        checks++; if (ps !== 4'd6) begin errors++; $display("FAIL timeout_phase got %0d want 6", ps); end
        checks++; if (hs !== 37) begin errors++; $display("FAIL timeout_handshakes got %0d want 37", hs); end
    endtask

    task automatic test_handshake_stress;
        bit gd; logic [9:0] m; logic c; logic [3:0] ps; int hs;
        req_drop_err = 0;
        req_after_ack_err = 0;
        run_cal(16'h0078, 16'h0000, -1, 1, gd, m, c, ps, hs);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL stress_done got %b want 1", gd); end
        checks++; if (m !== 10'h078) begin errors++; $display("FAIL stress_mask got %h want 078", m); end
        checks++; if (ps !== 4'd4) begin errors++; $display("FAIL stress_phase got %0d want 4", ps); end
        checks++; if (hs !== 22) begin errors++; $display("FAIL stress_handshakes got %0d want 22", hs); end
        checks++; if (req_drop_err !== 0) begin errors++; $display("FAIL stress_req_held got %0d drops want 0", req_drop_err); end
        checks++; if (req_after_ack_err !== 0) begin errors++; $display("FAIL stress_req_after_ack got %0d want 0", req_after_ack_err); end
    endtask

    task automatic test_start_ignored;
        int dc;
        bit gd;
        pass_pat = 16'h00E6; noresp = 16'h0000; ack_delay = 0; spurious = 0; hs_count = 0;
        dc = done_cnt;
        gd = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy_p1 got %b want 1", busy); end
        checks++; if (ifc.cmd_req !== 1'b0) begin errors++; $display("FAIL start_req_p1 got %b want 0", ifc.cmd_req); end
        @(negedge clk);
        checks++; if (phase_select !== 4'd0) begin errors++; $display("FAIL start_phase_p2 got %0d want 0", phase_select); end
        checks++; if (ifc.cmd_req !== 1'b1) begin errors++; $display("FAIL start_req_p2 got %b want 1", ifc.cmd_req); end
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 5000 && !gd; i++) begin
            if (done === 1'b1) gd = 1;
            else @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", gd); end
        checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt - dc); end
        checks++; if (hs_count !== 25) begin errors++; $display("FAIL restart_handshakes got %0d want 25", hs_count); end
        checks++; if (phase_select !== 4'd6) begin errors++; $display("FAIL restart_phase got %0d want 6", phase_select); end
    endtask

    task automatic test_reset_mid_scan;
        int dc;
        bit seen;
        pass_pat = 16'h0078; noresp = 16'h0000; ack_delay = 0; spurious = 0;
        seen = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (phase_select === 4'd5) seen = 1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midreset_reach_phase5 got %b want 1", seen); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (phase_select !== 4'd0) begin errors++; $display("FAIL midreset_phase got %0d want 0", phase_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (pass_mask !== 10'h000) begin errors++; $display("FAIL midreset_mask got %h want 000", pass_mask); end
        checks++; if (cal_ok !== 1'b0) begin errors++; $display("FAIL midreset_cal_ok got %b want 0", cal_ok); end
        checks++; if (ifc.cmd_req !== 1'b0) begin errors++; $display("FAIL midreset_cmd_req got %b want 0", ifc.cmd_req); end
        @(negedge clk) rst_n = 1'b1;
        dc = done_cnt;
        repeat (30) @(negedge clk);
        checks++; if (done_cnt !== dc) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", done_cnt - dc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle_busy got %b want 0", busy); end
        checks++; if (phase_select !== 4'd0) begin errors++; $display("FAIL midreset_idle_phase got %0d want 0", phase_select); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        expected_word = 32'hA5C3_1E69;
        manual_en = 1'b0;
        manual_phase = 4'd0;
        test_reset();
        test_window_select();
        test_single_window();
        test_no_pass();
        test_manual();
        test_timeout();
        test_handshake_stress();
        test_start_ignored();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miso_phase_calibrator.md
# miso_phase_calibrator

Automatic cable-delay calibration controller for the MISO phase selector. On request it sweeps `phase_select` across all sampling phases and, at each phase, triggers read transactions through the SPI sequencer. Each returned MISO word is compared against a known expected word, and the controller records a per-phase pass/fail mask. It then drives `phase_select` to the centre of the widest contiguous passing window. The block sits between host configuration registers, the SPI command sequencer and the phase selector mux.

## Interface
- `NUM_PHASES`, 10: number of selectable phases, scanned as 0..NUM_PHASES-1.
- `PHASE_W`, 4: width of `phase_select`.
- `WORD_W`, 32: MISO word width.
- `REPEATS`, 4: reads per phase; all must match for the phase to pass.
- `TIMEOUT`, 1023: cycles to wait for `miso_valid` before scoring the phase as a fail.
- `DEFAULT_PHASE`, 0: reset value of the calibrated phase.
- `dataclk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle calibration request.
- `expected_word`, in, WORD_W: reference word, stable while busy.
- `manual_en`, in, 1: host override of the phase when idle.
- `manual_phase`, in, PHASE_W: override value.
- `cmd_req`, out, 1: request one read transaction from the sequencer.
- `cmd_ack`, in, 1: sequencer accepted the request.
- `miso_valid`, in, 1: one-cycle strobe; `miso_word` is valid.
- `miso_word`, in, WORD_W: word from the phase selector.
- `phase_select`, out, PHASE_W: drives the phase selector.
- `busy`, out, 1: calibration in progress.
- `done`, out, 1: one-cycle pulse at completion.
- `cal_ok`, out, 1: at least one phase passed in the last calibration.
- `pass_mask`, out, NUM_PHASES: bit p set means phase p passed.

## Operation
- **States:** IDLE, SET_PHASE, REQ, WAIT_DATA, CHECK, PICK, DONE.
- **IDLE:**
  - `start`=1 moves to SET_PHASE, sets scan_phase=0, clears `pass_mask`, sets `busy`.
  - `start` in any other state is ignored.
- **SET_PHASE:** one settle cycle; the repeat count is cleared. Then REQ.
- **REQ:**
  - `cmd_req` is held high until `cmd_ack` is sampled high.
  - `cmd_req` is low in the cycle after the ack; the FSM moves to WAIT_DATA and clears the timeout counter.
- **WAIT_DATA:**
  - `miso_valid` latches `miso_word` and moves to CHECK.
  - The timeout counter reaching TIMEOUT scores the phase as a fail and goes to advance.
  - `miso_valid` outside WAIT_DATA is ignored.
- **CHECK:**
  - Mismatch: the phase fails immediately; remaining repeats are skipped.
  - Match and repeat count < REPEATS-1: increment the count, go to REQ.
  - Match on the last repeat: set `pass_mask[scan_phase]`.
- **Advance:** if scan_phase == NUM_PHASES-1, go to PICK; otherwise increment and go to SET_PHASE.
- **PICK:**
  - Find the longest run of consecutive ones in `pass_mask`; there is no wrap-around.
  - Ties go to the lowest start index.
  - Result phase = start + (len-1)/2, rounded down.
- **DONE:**
  - One cycle: `done`=1.
  - If any phase passed: cal_phase := result and `cal_ok`=1.
  - If no phase passed: cal_phase is unchanged and `cal_ok`=0.
  - Then IDLE, `busy`=0.
- **`phase_select` source:**
  - While busy: scan_phase.
  - Else if `manual_en`: `manual_phase`.
  - Else: cal_phase.

## Timing
- **Reset values:**
  - `phase_select`=DEFAULT_PHASE, cal_phase=DEFAULT_PHASE.
  - `cmd_req`, `busy`, `done`, `cal_ok` all 0; `pass_mask`=0; FSM in IDLE.
- **Reset mid-operation:** everything returns to the reset values immediately. A pending `cmd_ack` or `miso_valid` is dropped.
- All outputs are registered. `phase_select` reflects a source change one cycle later.
- **From `start`:**
  - `busy` rises at cycle +1.
  - `phase_select`=0 at cycle +2.
  - First `cmd_req` at cycle +2.
- **PICK** takes NUM_PHASES+1 cycles.
- **Completion outputs:**
  - `pass_mask`, `cal_ok` and cal_phase are valid in the `done` cycle.
  - `phase_select` shows cal_phase one cycle after `done`.
- **Comparison:** full WORD_W equality; no masking.

## Structure
- **Package `miso_cal_pkg`:** FSM state enum; default PHASE_W, REPEATS and TIMEOUT constants.
- **Sub-module `miso_cal_window_finder`:**
  - Sequentially scans `pass_mask` one bit per cycle, tracking current and best run start/length.
  - Outputs result phase and found flag after NUM_PHASES+1 cycles.
- The main FSM, the timeout counter and the `phase_select` mux live in `miso_phase_calibrator`.

## Test plan
- **Reset:** `reset_n` low mid-scan at phase 5 → all outputs return to reset values; `phase_select`=0, `busy`=0, no `done` pulse.
- **Single window:** sequencer model returns `expected_word` only at phases 3–6 → `pass_mask`=0x078, `cal_ok`=1, `phase_select`=4 after `done`, exactly 22 `cmd_req`/`cmd_ack` handshakes (16 on passing phases plus 6 early fails).
- **Window selection:**
  - Passes at 1–2 and 5–7 → `phase_select`=6.
  - Passes at 0–1 and 4–5 → `phase_select`=0 (tie, lowest start).
- **No pass:**
  - Prior cal_phase=4; every word mismatches → `pass_mask`=0, `cal_ok`=0, `phase_select`=4.
  - Set `manual_en`=1, `manual_phase`=7 → `phase_select`=7 one cycle later.
- **Timeout:** no `miso_valid` at phase 2, others pass → after 1023 cycles the scan continues; `pass_mask`=0x3FB, result phase=6.
- **Handshake stress:**
  - `cmd_ack` delayed 0–5 cycles → `cmd_req` held, no duplicate requests.
  - Spurious `miso_valid` in REQ → ignored.
  - `start` while busy → ignored.
